// File: rtl/count_monitor_pkg.sv
// Shared types and defaults for the count_monitor checker.
// The FSM encoding is visible on the state port, so it must stay fixed.
package count_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam int SIZE_DEFAULT       = 5;
    localparam int WRAP_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/count_monitor_wrap.sv
// Saturating, clearable event tally with a one-cycle pulse per counted event.
// A clear on the same edge as an event wins: the tally goes to zero and no pulse is produced.
module count_monitor_wrap #(
    parameter int Width = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [Width-1:0] tally,
    output logic             pulse
);

    localparam logic [Width-1:0] TallyMax = {Width{1'b1}};
    localparam logic [Width-1:0] TallyOne = {{(Width-1){1'b0}}, 1'b1};

    logic [Width-1:0] tally_r;
    logic             pulse_r;

    // Tally and pulse registers; the tally sticks at all-ones once reached.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tally_r <= {Width{1'b0}};
            pulse_r <= 1'b0;
        end else if (clear) begin
            tally_r <= {Width{1'b0}};
            pulse_r <= 1'b0;
        end else if (inc) begin
            pulse_r <= 1'b1;
            if (tally_r != TallyMax) begin
                tally_r <= tally_r + TallyOne;
            end else begin
                tally_r <= tally_r;
            end
        end else begin
            pulse_r <= 1'b0;
        end
    end

    assign tally = tally_r;
    assign pulse = pulse_r;

endmodule

// File: rtl/count_monitor.sv
// Locks onto an incrementing counter and flags any sample that breaks the +1 sequence.
// Wrap tallying is present only when COUNT_MONITOR_WRAP_COUNT_EN is defined.
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int Size      = SIZE_DEFAULT,
    parameter int WrapWidth = WRAP_WIDTH_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [Size-1:0]      count,
    input  logic                 clear,
    output logic [1:0]           state,
    output logic                 locked,
    output logic                 error,
    output logic                 error_pulse,
    output logic [Size-1:0]      expected,
    output logic [WrapWidth-1:0] wraps,
    output logic                 wrap_pulse
);

    localparam logic [Size-1:0] CountOne  = {{(Size-1){1'b0}}, 1'b1};
    localparam logic [Size-1:0] CountZero = {Size{1'b0}};

    state_t          state_r;
    logic [Size-1:0] expected_r;
    logic            locked_r;
    logic            error_r;
    logic            error_pulse_r;

    logic            match_s;
    logic [Size-1:0] next_expected_s;

    assign match_s         = (count == expected_r);
    assign next_expected_s = count + CountOne;

    // Sequence-tracking FSM; clear beats a same-edge mismatch for the error flag only.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r       <= IDLE;
            expected_r    <= CountZero;
            locked_r      <= 1'b0;
            error_r       <= 1'b0;
            error_pulse_r <= 1'b0;
        end else begin
            error_pulse_r <= 1'b0;
            if (clear) begin
                error_r <= 1'b0;
            end else begin
                error_r <= error_r;
            end
            if (!enable) begin
                state_r  <= IDLE;
                locked_r <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        expected_r <= next_expected_s;
                        state_r    <= ACQUIRE;
                        locked_r   <= 1'b0;
                    end
                    ACQUIRE: begin
                        expected_r <= next_expected_s;
                        if (match_s) begin
                            state_r  <= TRACK;
                            locked_r <= 1'b1;
                        end else begin
                            state_r  <= ACQUIRE;
                        end
                    end
                    TRACK: begin
                        if (match_s) begin
                            expected_r <= next_expected_s;
                        end else begin
                            // expected_r is frozen here so FAULT reports the value that was missed
                            state_r  <= FAULT;
                            locked_r <= 1'b0;
                            if (!clear) begin
                                error_r       <= 1'b1;
                                error_pulse_r <= 1'b1;
                            end else begin
                                error_pulse_r <= 1'b0;
                            end
                        end
                    end
                    FAULT: begin
                        if (clear) begin
                            state_r <= IDLE;
                        end else begin
                            state_r <= FAULT;
                        end
                    end
                    default: begin
                        state_r  <= IDLE;
                        locked_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state       = state_r;
    assign locked      = locked_r;
    assign error       = error_r;
    assign error_pulse = error_pulse_r;
    assign expected    = expected_r;

`ifdef COUNT_MONITOR_WRAP_COUNT_EN
    logic wrap_event_s;

    // A matched 0 in TRACK implies the previous sample was all-ones.
    assign wrap_event_s = enable && (state_r == TRACK) && match_s && (count == CountZero);

    count_monitor_wrap #(
        .Width (WrapWidth)
    ) u_wrap (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .inc   (wrap_event_s),
        .tally (wraps),
        .pulse (wrap_pulse)
    );
`else
    assign wraps      = {WrapWidth{1'b0}};
    assign wrap_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: bench-side counter model drives count, outputs sampled 1 ns after each edge.
module tb_count_monitor;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [4:0] count;
    logic       clear;
    logic [1:0] state;
    logic       locked;
    logic       error;
    logic       error_pulse;
    logic [4:0] expected;
    logic [7:0] wraps;
    logic       wrap_pulse;

    int         vectors;
    int         miscompares;
    logic [4:0] cnt;

    count_monitor #(.Size(5), .WrapWidth(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .count       (count),
        .clear       (clear),
        .state       (state),
        .locked      (locked),
        .error       (error),
        .error_pulse (error_pulse),
        .expected    (expected),
        .wraps       (wraps),
        .wrap_pulse  (wrap_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One edge sampling the current count, then the modelled upstream counter increments.
    task automatic adv();
        tick();
        cnt   = cnt + 5'd1;
        count = cnt;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; clear = 1'b0; cnt = 5'd0; count = 5'd0;
        repeat (3) tick();
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL rst_state got %0d want 0", state); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL rst_locked got %b want 0", locked); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL rst_error got %b want 0", error); end
        vectors++; if (error_pulse !== 1'b0) begin miscompares++; $display("FAIL rst_epulse got %b want 0", error_pulse); end
        vectors++; if (expected !== 5'd0) begin miscompares++; $display("FAIL rst_expected got %0d want 0", expected); end
        vectors++; if (wraps !== 8'd0) begin miscompares++; $display("FAIL rst_wraps got %0d want 0", wraps); end
        vectors++; if (wrap_pulse !== 1'b0) begin miscompares++; $display("FAIL rst_wpulse got %b want 0", wrap_pulse); end
        reset = 1'b1;
        tick();
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL rst_release_state got %0d want 0", state); end
    endtask

    task automatic test_lock();
        logic [4:0] s;
        logic [4:0] e;
        cnt = 5'd0; count = 5'd0; enable = 1'b1;
        adv();
        vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL lock_acq_state got %0d want 1", state); end
        vectors++; if (expected !== 5'd1) begin miscompares++; $display("FAIL lock_acq_expected got %0d want 1", expected); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL lock_acq_locked got %b want 0", locked); end
        adv();
        vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL lock_track_state got %0d want 2", state); end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL lock_track_locked got %b want 1", locked); end
        vectors++; if (expected !== 5'd2) begin miscompares++; $display("FAIL lock_track_expected got %0d want 2", expected); end
        for (int i = 0; i < 100; i++) begin
            s = cnt;
            e = s + 5'd1;
            adv();
            vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL run_error cycle %0d got %b want 0", i, error); end
            vectors++; if (expected !== e) begin miscompares++; $display("FAIL run_expected cycle %0d got %0d want %0d", i, expected, e); end
            vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL run_state cycle %0d got %0d want 2", i, state); end
        end
    endtask

    task automatic test_wrap();
        logic [4:0] s;
        logic       exp_wp;
        int         pulses;
        logic [7:0] exp_wraps;
        int         exp_pulses;
        clear = 1'b1;
        adv();
        clear = 1'b0;
        vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL wrap_clr_state got %0d want 2", state); end
        vectors++; if (wraps !== 8'd0) begin miscompares++; $display("FAIL wrap_clr_wraps got %0d want 0", wraps); end
        pulses = 0;
        for (int i = 0; i < 64; i++) begin
            s = cnt;
            adv();
`ifdef COUNT_MONITOR_WRAP_COUNT_EN
            exp_wp = (s == 5'd0);
`else
            exp_wp = 1'b0;
`endif
            if (wrap_pulse === 1'b1) pulses++;
            vectors++; if (wrap_pulse !== exp_wp) begin miscompares++; $display("FAIL wrap_pulse sample %0d got %b want %b", s, wrap_pulse, exp_wp); end
        end
`ifdef COUNT_MONITOR_WRAP_COUNT_EN
        exp_wraps = 8'd2; exp_pulses = 2;
`else
        exp_wraps = 8'd0; exp_pulses = 0;
`endif
        vectors++; if (wraps !== exp_wraps) begin miscompares++; $display("FAIL wrap_tally got %0d want %0d", wraps, exp_wraps); end
        vectors++; if (pulses != exp_pulses) begin miscompares++; $display("FAIL wrap_pulse_count got %0d want %0d", pulses, exp_pulses); end
    endtask

    task automatic test_mismatch();
        for (int i = 0; i < 32 && cnt != 5'd7; i++) adv();
        adv();
        cnt = 5'd9; count = 5'd9;
        tick();
        vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL mm_error got %b want 1", error); end
        vectors++; if (error_pulse !== 1'b1) begin miscompares++; $display("FAIL mm_epulse got %b want 1", error_pulse); end
        vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL mm_state got %0d want 3", state); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL mm_locked got %b want 0", locked); end
        cnt = 5'd10; count = 5'd10;
        tick();
        vectors++; if (error_pulse !== 1'b0) begin miscompares++; $display("FAIL mm_epulse_drop got %b want 0", error_pulse); end
        vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL mm_error_sticky got %b want 1", error); end
        vectors++; if (expected !== 5'd8) begin miscompares++; $display("FAIL mm_expected_hold got %0d want 8", expected); end
        vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL mm_state_hold got %0d want 3", state); end
        enable = 1'b0;
        tick();
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL dis_state got %0d want 0", state); end
        vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL dis_error_kept got %b want 1", error); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL idle_clr_state got %0d want 0", state); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL idle_clr_error got %b want 0", error); end
    endtask

    task automatic test_upstream_reset();
        enable = 1'b1; cnt = 5'd20; count = 5'd20;
        repeat (4) adv();
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL ur_locked got %b want 1", locked); end
        cnt = 5'd0; count = 5'd0; clear = 1'b1;
        tick();
        clear = 1'b0;
        vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL ur_state got %0d want 3", state); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL ur_error got %b want 0", error); end
        vectors++; if (error_pulse !== 1'b0) begin miscompares++; $display("FAIL ur_epulse got %b want 0", error_pulse); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL ur_locked_drop got %b want 0", locked); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL ur_clr_state got %0d want 0", state); end
    endtask

    task automatic test_reset_in_fault();
        logic [7:0] exp_wraps;
`ifdef COUNT_MONITOR_WRAP_COUNT_EN
        exp_wraps = 8'd5;
`else
        exp_wraps = 8'd0;
`endif
        cnt = 5'd0; count = 5'd0;
        adv();
        adv();
        clear = 1'b1;
        adv();
        clear = 1'b0;
        repeat (160) adv();
        vectors++; if (wraps !== exp_wraps) begin miscompares++; $display("FAIL rf_wraps got %0d want %0d", wraps, exp_wraps); end
        count = cnt - 5'd1;
        tick();
        vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL stuck_state got %0d want 3", state); end
        vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL stuck_error got %b want 1", error); end
        vectors++; if (wraps !== exp_wraps) begin miscompares++; $display("FAIL stuck_wraps got %0d want %0d", wraps, exp_wraps); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL rf_state got %0d want 0", state); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL rf_error got %b want 0", error); end
        vectors++; if (wraps !== 8'd0) begin miscompares++; $display("FAIL rf_wraps_zero got %0d want 0", wraps); end
        vectors++; if (expected !== 5'd0) begin miscompares++; $display("FAIL rf_expected got %0d want 0", expected); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL rf_locked got %b want 0", locked); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_lock();
        test_wrap();
        test_mismatch();
        test_upstream_reset();
        test_reset_in_fault();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/count_monitor.md
# count_monitor

Downstream checker for the `counter` block. Samples `count` every `clock` rising edge and locks onto the increment sequence. Once locked, it flags any sample that is not the previous value plus one, modulo 2^Size, and counts wrap-arounds. It lets the Ruby-VPI bench and on-chip logic read a single pass/fail status instead of re-deriving the sequence.

## Interface
- `Size`, 5, width of the monitored count; must match the upstream counter.
- `WrapWidth`, 8, width of the wrap-around tally.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the `clock` rising edge.
- `enable`  in  1  monitor active; low forces IDLE.
- `count`  in  Size  value from the upstream counter.
- `clear`  in  1  clears sticky error and wrap tally; returns FAULT to IDLE.
- `state`  out  2  current FSM state encoding.
- `locked`  out  1  high only in TRACK.
- `error`  out  1  sticky mismatch flag.
- `error_pulse`  out  1  one-cycle pulse on the cycle a mismatch is registered.
- `expected`  out  Size  value required on the next sample (previous sample + 1).
- `wraps`  out  WrapWidth  saturating count of observed all-ones→0 transitions.
- `wrap_pulse`  out  1  one-cycle pulse per wrap.

## Operation
- Reset (`reset`=0 at an edge): state=IDLE; `locked`, `error`, `error_pulse`, `wrap_pulse`=0; `expected`=0; `wraps`=0. Reset dominates every other input.
- IDLE: `enable`=1 → capture `count`, `expected`=count+1, go to ACQUIRE.
- ACQUIRE:
  - `count`==`expected` → TRACK; `locked`=1.
  - Otherwise recapture `count` and stay in ACQUIRE. No error is raised while acquiring.
- TRACK, each edge:
  - `count`==`expected` → stay; `expected`=count+1.
  - Mismatch → FAULT; `error`=1; `error_pulse`=1 for one cycle; `locked`=0.
  - A stuck value or an upstream counter reset mid-sequence is a mismatch.
- FAULT: holds `error` and `expected`; ignores `count`. Leaves only on `clear`=1 → IDLE.
- `enable`=0 in any state → IDLE next edge. `locked`=0. `error` and `wraps` are retained.
- `clear`=1 outside FAULT clears `error` and `wraps` without changing state.
- `clear` and a mismatch on the same edge: clear wins. `error` stays 0 and no pulse is generated, but state still moves to FAULT.
- Arithmetic:
  - `expected` is Size bits and wraps (all-ones + 1 = 0).
  - A wrap is a matched sample of 0 whose previous sample was all-ones, in TRACK only.
  - `wraps` saturates at 2^WrapWidth−1.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Latency: a bad `count` sampled at edge N gives `error`=1 and `error_pulse`=1 after edge N, visible during cycle N+1.
- Lock latency: `enable` raised before edge N with a correctly incrementing counter → IDLE→ACQUIRE at N, TRACK/`locked`=1 after N+1.
- `wrap_pulse` asserts after the edge that samples the 0 following all-ones.
- `count` must be stable at the sampling edge. The upstream counter updates on the same edge, so the value sampled is the pre-edge value.

## Configuration
- `COUNT_MONITOR_WRAP_COUNT_EN` defined: the wrap detection, `wraps` tally and `wrap_pulse` logic are present.
- Undefined: `wraps` is tied to 0 and `wrap_pulse` to 0, and the logic is removed. Ports remain so the bench hookup is unchanged. Mismatch checking is unaffected.

## Structure
- `count_monitor_pkg` holds:
  - the state typedef with encodings IDLE=2'd0, ACQUIRE=2'd1, TRACK=2'd2, FAULT=2'd3;
  - default `Size`/`WrapWidth` constants.
- Sub-module `count_monitor_wrap`: a saturating, clearable tally with a pulse output. Instantiated only under `COUNT_MONITOR_WRAP_COUNT_EN`.

## Test plan
- Reset held 3 cycles, `enable`=0 → `state`=0, all outputs 0; after release, still IDLE.
- `enable`=1, counter running from 0 → `locked`=1 two edges after enable, `expected` tracks count+1, `error` stays 0 for 100 cycles.
- Size=5, 64 clean cycles in TRACK → `wraps`=2 with two `wrap_pulse` pulses on the samples 31→0.
  - With the macro undefined: `wraps`=0 and no pulses.
- Force `count` 7→9 while tracking → `error`=1 and `error_pulse` for one cycle after the edge sampling 9; `state`=FAULT; then `clear`=1 → IDLE, `error`=0.
- Pulse the upstream counter's reset while tracking → mismatch on the 0 sample, FAULT. Assert `clear` on that same edge → `error` stays 0, `state`=FAULT.
- Drive `reset`=0 while in FAULT with `wraps`=5 → all outputs 0 and `state`=IDLE after that edge.
